// File: rtl/suma_pkg.sv
// Shared widths and FSM state type for the sequential 20-bit adder.
// Imported by suma_fmt and suma_secuencial.
package suma_pkg;

    localparam int OPW  = 20;
    localparam int SUMW = 21;
    localparam int BUSW = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD1,
        LOAD2,
        ADD,
        OUT
    } suma_estado_t;

    // Widen a sum to the output bus with zero fill.
    function automatic logic [BUSW-1:0] ext_suma(
        input logic [SUMW-1:0] s
    );
        return {{(BUSW-SUMW){1'b0}}, s};
    endfunction

endpackage

// File: rtl/suma_fmt.sv
// Combinational operand formatter: 32-bit bus in, 20-bit value zero-extended out.
// Ports: entrada (raw bus), salida (formatted). Macro SUMA_SAT_EN selects saturation.
module suma_fmt
    import suma_pkg::*;
(
    input  logic [BUSW-1:0] entrada,
    output logic [BUSW-1:0] salida
);

    localparam logic [BUSW-1:0] MAXV = {{(BUSW-OPW){1'b0}}, {OPW{1'b1}}};

    logic [BUSW-1:0] truncado;

    assign truncado = {{(BUSW-OPW){1'b0}}, entrada[OPW-1:0]};

`ifdef SUMA_SAT_EN
    // Any bit above the operand width means the value does not fit.
    logic excede;

    assign excede = |entrada[BUSW-1:OPW];
    assign salida = excede ? MAXV : truncado;
`else
    logic unused_alto;

    assign unused_alto = ^{entrada[BUSW-1:OPW], MAXV};
    assign salida      = truncado;
`endif

endmodule

// File: rtl/suma_secuencial.sv
// Strobe-driven two-operand adder: capture numero1, numero2, optionally add and publish.
// Ports: clock, reset_n, validar, listosNumeros, numero1/2 in; numero1f/2f, sumatotal(f), recibido1/2 out.
module suma_secuencial
    import suma_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            validar,
    input  logic            listosNumeros,
    input  logic [BUSW-1:0] numero1,
    input  logic [BUSW-1:0] numero2,
    output logic [BUSW-1:0] numero1f,
    output logic [BUSW-1:0] numero2f,
    output logic [SUMW-1:0] sumatotal,
    output logic [BUSW-1:0] sumatotalf,
    output logic            recibido1,
    output logic            recibido2
);

    suma_estado_t estado;
    suma_estado_t estado_sig;

    logic            validar_q;
    logic            inicio;
    logic            go;
    logic            go_sig;
    logic            cargar1;
    logic            cargar2;
    logic            sumar;
    logic            publicar;
    logic [BUSW-1:0] fmt1;
    logic [BUSW-1:0] fmt2;
    logic [SUMW-1:0] suma;

    suma_fmt u_fmt1 (
        .entrada (numero1),
        .salida  (fmt1)
    );

    suma_fmt u_fmt2 (
        .entrada (numero2),
        .salida  (fmt2)
    );

    // validar_q clears on reset, so a strobe held through release starts once.
    assign inicio = validar & ~validar_q;

    assign suma = SUMW'(numero1f[OPW-1:0])
                + SUMW'(numero2f[OPW-1:0]);

    always_comb begin
        estado_sig = estado;
        go_sig     = go;
        cargar1    = 1'b0;
        cargar2    = 1'b0;
        sumar      = 1'b0;
        publicar   = 1'b0;
        unique case (estado)
            IDLE: begin
                if (inicio) begin
                    go_sig     = listosNumeros;
                    estado_sig = LOAD1;
                end
            end
            LOAD1: begin
                cargar1    = 1'b1;
                estado_sig = LOAD2;
            end
            LOAD2: begin
                cargar2    = 1'b1;
                estado_sig = go ? ADD : IDLE;
            end
            ADD: begin
                sumar      = 1'b1;
                estado_sig = OUT;
            end
            OUT: begin
                publicar   = 1'b1;
                estado_sig = IDLE;
            end
            default: begin
                estado_sig = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= IDLE;
            go        <= 1'b0;
            validar_q <= 1'b0;
        end else begin
            estado    <= estado_sig;
            go        <= go_sig;
            validar_q <= validar;
        end
    end

    // Acknowledge pulses are registered alongside the data they flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            numero1f   <= '0;
            numero2f   <= '0;
            sumatotal  <= '0;
            sumatotalf <= '0;
            recibido1  <= 1'b0;
            recibido2  <= 1'b0;
        end else begin
            recibido1 <= cargar1;
            recibido2 <= cargar2;
            if (cargar1) begin
                numero1f <= fmt1;
            end
            if (cargar2) begin
                numero2f <= fmt2;
            end
            if (sumar) begin
                sumatotal <= suma;
            end
            if (publicar) begin
                sumatotalf <= ext_suma(sumatotal);
            end
        end
    end

endmodule

// File: tb/tb_suma_secuencial.sv
// Self-checking bench for suma_secuencial: directed steps plus random transactions.
// Compile with SUMA_SAT_EN defined to exercise the saturating build.
module tb_suma_secuencial;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        validar = 1'b0;
    logic        listosNumeros = 1'b0;
    logic [31:0] numero1 = '0;
    logic [31:0] numero2 = '0;
    logic [31:0] numero1f;
    logic [31:0] numero2f;
    logic [20:0] sumatotal;
    logic [31:0] sumatotalf;
    logic        recibido1;
    logic        recibido2;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [31:0] m1 = '0;
    logic [31:0] m2 = '0;
    logic [20:0] msum = '0;
    logic [31:0] msumf = '0;

    suma_secuencial dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .validar       (validar),
        .listosNumeros (listosNumeros),
        .numero1       (numero1),
        .numero2       (numero2),
        .numero1f      (numero1f),
        .numero2f      (numero2f),
        .sumatotal     (sumatotal),
        .sumatotalf    (sumatotalf),
        .recibido1     (recibido1),
        .recibido2     (recibido2)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] fmt_ref(input logic [31:0] x);
`ifdef SUMA_SAT_EN
        return (x > 32'd1048575) ? 32'd1048575 : x;
`else
        return x % 32'd1048576;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic r1, input logic r2);
        chk({tag, "/numero1f"}, numero1f, m1);
        chk({tag, "/numero2f"}, numero2f, m2);
        chk({tag, "/sumatotal"}, {11'b0, sumatotal}, {11'b0, msum});
        chk({tag, "/sumatotalf"}, sumatotalf, msumf);
        chk({tag, "/recibido1"}, {31'b0, recibido1}, {31'b0, r1});
        chk({tag, "/recibido2"}, {31'b0, recibido2}, {31'b0, r2});
    endtask

    task automatic ciclo();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Runs one transaction from the start edge to the publish edge.
    task automatic transaccion(input logic [31:0] a, input logic [31:0] b,
                               input logic g, input bit ya_arrancado,
                               input bit relanzar);
        if (!ya_arrancado) begin
            numero1       = a;
            numero2       = b;
            validar       = 1'b1;
            listosNumeros = g;
        end
        ciclo();
        validar       = 1'b0;
        listosNumeros = 1'($urandom);
        chk_all("k", 1'b0, 1'b0);
        ciclo();
        m1 = fmt_ref(a);
        chk_all("k+1", 1'b1, 1'b0);
        numero1 = $urandom;
        if (relanzar) validar = 1'b1;
        ciclo();
        m2 = fmt_ref(b);
        chk_all("k+2", 1'b0, 1'b1);
        numero2 = $urandom;
        ciclo();
        if (g) msum = 21'(m1 + m2);
        chk_all("k+3", 1'b0, 1'b0);
        ciclo();
        if (g) msumf = {11'b0, msum};
        chk_all("k+4", 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with the strobe already high and no sum requested.
        validar       = 1'b1;
        listosNumeros = 1'b0;
        numero1       = 32'd2360;
        numero2       = 32'd1000;
        ciclo();
        ciclo();
        chk_all("reset", 1'b0, 1'b0);
        reset_n = 1'b1;
        transaccion(32'd2360, 32'd1000, 1'b0, 1'b1, 1'b0);
        chk({"no_go/sumatotal"}, {11'b0, sumatotal}, 32'd0);

        // Basic add with a one-cycle strobe.
        ciclo();
        transaccion(32'd2360, 32'd1000, 1'b1, 1'b0, 1'b0);
        chk("basic/sumatotalf", sumatotalf, 32'h00000D20);

        // Eight identical transactions spaced 52 cycles apart.
        for (int i = 0; i < 8; i++) begin
            transaccion(32'd2360, 32'd1000, 1'b1, 1'b0, 1'b0);
            for (int j = 0; j < 47; j++) begin
                ciclo();
                if (j % 16 == 0) chk_all("gap", 1'b0, 1'b0);
            end
        end

        // Operand wider than 20 bits: truncation or saturation.
        transaccion(32'h00100005, 32'h000FFFFF, 1'b1, 1'b0, 1'b0);
`ifdef SUMA_SAT_EN
        chk("wide/sumatotal", {11'b0, sumatotal}, 32'h001FFFFE);
`else
        chk("wide/sumatotal", {11'b0, sumatotal}, 32'h00100004);
`endif

        // A second rise during the transaction is ignored.
        ciclo();
        transaccion(32'd7, 32'd9, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            ciclo();
            chk_all("ignorado", 1'b0, 1'b0);
        end
        validar = 1'b0;
        ciclo();

        // Random back-to-back transactions against the model.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        g;
            int          gap;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(1, 0) == 0) a = a & 32'h000FFFFF;
            if ($urandom_range(1, 0) == 0) b = b & 32'h000FFFFF;
            g = 1'($urandom_range(1, 0));
            transaccion(a, b, g, 1'b0, 1'b0);
            gap = $urandom_range(3, 0);
            for (int j = 0; j < gap; j++) begin
                ciclo();
                chk_all("rnd_gap", 1'b0, 1'b0);
            end
        end

        // Reset asserted while the second operand is loading.
        numero1       = 32'd123;
        numero2       = 32'd456;
        validar       = 1'b1;
        listosNumeros = 1'b1;
        ciclo();
        validar = 1'b0;
        ciclo();
        chk("abort/numero1f", numero1f, fmt_ref(32'd123));
        reset_n = 1'b0;
        #1;
        m1    = '0;
        m2    = '0;
        msum  = '0;
        msumf = '0;
        chk_all("abort", 1'b0, 1'b0);
        ciclo();
        chk_all("abort+1", 1'b0, 1'b0);
        reset_n = 1'b1;
        ciclo();
        chk_all("abort+2", 1'b0, 1'b0);
        ciclo();
        chk_all("abort+3", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/suma_secuencial.md
# suma_secuencial

Two-operand 20-bit adder with a strobe-driven capture/acknowledge sequence. A rising edge on `validar` starts a transaction. Each transaction latches `numero1`, then `numero2`, into formatted operand registers and acknowledges each capture. If `listosNumeros` was high at the start edge, the transaction also adds the operands and publishes the result in 21-bit and 32-bit form. It sits between a slow operand source (keypad/host register file) and a display/output stage.

## Interface
Parameters: none. Widths are fixed constants (operand 20 b, sum 21 b, bus 32 b).
- `clock` input 1 — single system clock; all logic is rising-edge triggered.
- `reset_n` input 1 — reset, asynchronous and active-low.
- `validar` input 1 — transaction strobe; only its rising edge is used.
- `listosNumeros` input 1 — "operands ready"; sampled on the same edge as the `validar` rise. Selects whether the sum is computed.
- `numero1` input 32 — first operand bus.
- `numero2` input 32 — second operand bus.
- `numero1f` output 32 — formatted first operand: 20-bit value, zero-extended.
- `numero2f` output 32 — formatted second operand: 20-bit value, zero-extended.
- `sumatotal` output 21 — `numero1f[19:0] + numero2f[19:0]`; never overflows.
- `sumatotalf` output 32 — `sumatotal` zero-extended, registered one cycle after `sumatotal`.
- `recibido1` output 1 — one-cycle pulse when `numero1f` is updated.
- `recibido2` output 1 — one-cycle pulse when `numero2f` is updated.

## Operation
- Edge detect:
  - `inicio = validar & ~validar_q`, where `validar_q` is `validar` registered.
  - `validar_q` resets to 0, so `validar` held high through reset release yields exactly one start.
- FSM states: IDLE, LOAD1, LOAD2, ADD, OUT.
  - IDLE: on `inicio`, latch `go <= listosNumeros` and go to LOAD1. Otherwise stay.
  - LOAD1: `numero1f <= fmt(numero1)`, `recibido1 = 1` → LOAD2.
  - LOAD2: `numero2f <= fmt(numero2)`, `recibido2 = 1` → ADD if `go`, else IDLE.
  - ADD: `sumatotal <= numero1f[19:0] + numero2f[19:0]` → OUT.
  - OUT: `sumatotalf <= {11'b0, sumatotal}` → IDLE.
- `inicio` is ignored outside IDLE; no queuing.
- `fmt(x)` is `{12'b0, x[19:0]}` (truncation) unless saturation is configured.
- All outputs hold their values between transactions.
- A transaction without `go` refreshes the operands but leaves both sums unchanged.

## Timing
- Reset (async assert, sync release): state = IDLE, `go` = 0, all outputs = 0.
- Let `inicio` be sampled at edge k:
  - `numero1f` and `recibido1` change after edge k+1.
  - `numero2f` and `recibido2` change after edge k+2.
  - `sumatotal` changes after edge k+3.
  - `sumatotalf` changes after edge k+4.
- Operands are sampled in their load cycle, not at edge k.
- Next start is accepted from the edge after OUT, or after LOAD2 when `go` = 0.
- Minimum spacing between starts: 5 cycles with `go`, 3 cycles without.
- `recibido1` and `recibido2` are never high together. Each lasts exactly one cycle.
- `reset_n` low mid-transaction aborts it immediately and clears all outputs.

## Configuration
- `SUMA_SAT_EN` defined: `fmt` saturates. If `x[31:20] != 0`, the value becomes `32'h000FFFFF`.
- `SUMA_SAT_EN` undefined: `fmt` truncates to `x[19:0]`.
- All other behaviour is identical in both builds.

## Structure
- Package `suma_pkg`:
  - `OPW=20`, `SUMW=21`, `BUSW=32`.
  - FSM state typedef `suma_estado_t`.
- Sub-module `suma_fmt`: combinational 32→32 operand formatter containing the `SUMA_SAT_EN` switch. Instantiated twice, once per operand.

## Test plan
- Reset with `validar`=1 and `listosNumeros`=0, then release. Expect all outputs 0 during reset. Then one transaction: `numero1f`=2360 and `numero2f`=1000 with single pulses on `recibido1` and `recibido2`. Sums stay 0.
- `numero1`=2360, `numero2`=1000; 1-cycle pulse of `validar`+`listosNumeros`. Expect `sumatotal`=3360 at k+3 and `sumatotalf`=32'h00000D20 at k+4.
- Repeat the pulse 8 times, 52 cycles apart. Expect 8 identical transactions, each with 1 `recibido1` and 1 `recibido2` pulse.
- `numero1`=32'h00100005, `numero2`=32'h000FFFFF, with `go`:
  - Without `SUMA_SAT_EN`: `sumatotal`=21'h100004.
  - With `SUMA_SAT_EN`: `sumatotal`=21'h1FFFFE.
- Second `validar` rise 2 cycles after the first is ignored. Assert `reset_n` low during LOAD2: outputs 0 at once, and no `recibido2` pulse.
